// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble-sort processor: word width, opcodes,
// the terminating halt word and the fetch-stage state encoding.
package bubble_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OPC_BEQ = 6'b011000;
    localparam logic [5:0] OPC_BLE = 6'b011110;
    localparam logic [5:0] OPC_J   = 6'd2;

    // beq $0,$0,0 -- the program parks itself on this self-loop
    localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = {OPC_BEQ, 26'd0};

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register, with stall, redirect squash and halt parking.
import bubble_pkg::*;

module instr_fetch #(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'd0,
    parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_pc_next,
    output logic              halted,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [WORD_W-1:0] if_instr_q, if_instr_d;
    logic [WORD_W-1:0] if_pc_q, if_pc_d;
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FETCH_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Redirect outranks stall so a squashed word can never linger in IF/ID.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d    = imem_data;
                    if_pc_d       = pc_q;
                    if_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 1'b1;
                    if (imem_data == HALT_WORD) begin
                        state_d = FETCH_HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            FETCH_HALT: begin
                if (redirect_valid) begin
                    state_d    = FETCH_RUN;
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_next  = if_pc_q + 1'b1;
    assign halted      = (state_q == FETCH_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the bubble-sort processor. Holds the program counter, drives the read address of the word-addressed instruction memory (`Text`), and registers the returned word into the IF/ID pipeline register for the decoder. It handles stalls, branch/jump redirects with a one-bubble squash, and halting on the program's terminating self-loop word.

## Interface
- `RESET_PC`, 32'd0: PC value loaded at reset, a word address.
- `HALT_WORD`, 32'h6000_0000: instruction that stops fetching (`beq $0,$0,0`, opcode 6'b011000).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset. `rst==0` at a rising edge resets all state.
- `imem_addr` out 32: combinational copy of `pc`; drives `Text.r_addr`.
- `imem_data` in 32: combinational read data from `Text.dout`, valid in the same cycle.
- `stall` in 1: decode/execute cannot accept an instruction; hold the IF/ID register.
- `redirect_valid` in 1: a taken branch or jump resolved this cycle.
- `redirect_pc` in 32: target word address, sampled when `redirect_valid==1`.
- `if_valid` out 1: IF/ID holds a live instruction.
- `if_instr` out 32: IF/ID instruction.
- `if_pc` out 32: word address of `if_instr`.
- `if_pc_next` out 32: `if_pc + 1`, used by the branch offset adder.
- `halted` out 1: fetch is parked in HALT.
- `fetch_count` out 32: number of instructions delivered with `if_valid` since reset.

## Operation
- Word addressing: the PC increments by 1 per instruction. Arithmetic is 32-bit modulo 2^32, so `32'hFFFF_FFFF + 1 = 0`. The memory uses only `pc[15:0]`, so aliasing above 0xFFFF is the memory's behaviour, not an error.
- FSM states: RUN and HALT. Reset enters RUN.
- RUN, evaluated in this priority order each cycle:
  - `redirect_valid`:
    - `pc <= redirect_pc`; `if_valid <= 0`, squashing the wrong-path word.
    - Redirect wins over `stall` and over halt detection.
    - `fetch_count` is unchanged.
  - `stall`: `pc`, the IF/ID register and `fetch_count` are all held.
  - `imem_data == HALT_WORD`:
    - Load IF/ID with `{HALT_WORD, pc}` and set `if_valid <= 1`.
    - `pc` is held; go to HALT; increment `fetch_count`.
  - Otherwise:
    - Load IF/ID with `{imem_data, pc}` and set `if_valid <= 1`.
    - `pc <= pc + 1`; increment `fetch_count`.
- HALT:
  - `halted = 1`; `pc` is frozen.
  - When `stall==0`, `if_valid <= 0`, so the halt word is consumed exactly once.
  - `redirect_valid` returns the block to RUN with `pc <= redirect_pc` and `if_valid <= 0`. This recovers from a halt word fetched on a wrong path.
  - `halted` deasserts on the cycle after the redirect.
- `if_pc_next` is combinational from `if_pc`.
- `fetch_count` wraps at 2^32.
- The block never writes instruction memory; `Text.w_en` is owned elsewhere.

## Timing
- Reset values:
  - `pc=RESET_PC`, so `imem_addr=RESET_PC`.
  - `if_valid=0`, `if_instr=0`, `if_pc=0`, `if_pc_next=1`.
  - `halted=0`, `fetch_count=0`, state RUN.
- First instruction: appears on IF/ID one edge after reset deasserts.
- Latency: `imem_addr` to `if_instr` is 1 cycle. Sustained throughput is 1 instruction per cycle with no stall.
- Redirect penalty: exactly 1 bubble. The target instruction is on IF/ID 2 edges after the `redirect_valid` cycle.
- Reset asserted mid-operation: overrides everything at that edge, including stall, redirect and HALT.
- `stall` and `redirect_valid` high together: redirect is taken and the IF/ID register is squashed. The downstream stage must tolerate `if_valid` dropping while it is stalled.

## Structure
- Shared package `bubble_pkg`:
  - `HALT_WORD` default.
  - Opcode constants: BEQ 6'b011000, BLE 6'b011110, J 6'd2.
  - Fetch-state enum {RUN, HALT}.
  - Word-width constant 32.
- Single module, no sub-module. The IF/ID register is inline.

## Test plan
- **Straight-line fetch.** Memory words 0..4 preloaded, no stall. Required: `if_pc` = 0,1,2,3,4 on consecutive cycles, `if_instr` matches memory, `fetch_count` = 5.
- **Stall.** Assert `stall` for 3 cycles while `if_pc=2`. Required: IF/ID holds `if_pc=2` with the same instruction, `imem_addr=3` is held, and `if_pc=3` follows on the cycle after release.
- **Redirect with stall.** `redirect_valid=1`, `redirect_pc=5`, with `stall=1` in the same cycle. Required: next cycle `if_valid=0`; the following cycle `if_pc=5`; `fetch_count` is not incremented for the squashed word.
- **Halt.** `HALT_WORD` placed at address 16; run the full bubble-sort program. Required: `if_instr=32'h6000_0000` is delivered once, then `halted=1`, `if_valid=0`, `imem_addr` frozen at 16.
- **Leaving HALT.** In HALT, pulse `redirect_pc=3`. Required: `halted=0` and `if_pc=3` two edges later.
- **Wrap and reset.** Redirect to `32'hFFFF_FFFF`. Required: next `if_pc_next=0` and `imem_addr=0`. Then drive `rst=0` for one edge mid-run: all outputs return to their reset values.
